// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared constants for the decode stage and its register file.
//   DECODE_DATA_W : default operand / register width in bits
//   DECODE_ADDR_W : default register address width (NREGS = 2**ADDR_W)
package decode_pkg;

    localparam int DECODE_DATA_W = 16;
    localparam int DECODE_ADDR_W = 3;

endpackage : decode_pkg

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   NREGS x DATA_W register file with two combinational read ports and one
//   write port. A write in progress is forwarded to any read port addressing
//   the same entry, so a consumer in the same cycle sees the new value.
//   Ports:
//     clk, rst           clock, synchronous active-high reset (clears all entries)
//     wb_en/addr/data    write port
//     rd_addr_a/b        read port addresses
//     rd_data_a/b        read port data (bypassed)
module regfile_bypass
    import decode_pkg::*;
#(
    parameter int DATA_W = DECODE_DATA_W,
    parameter int ADDR_W = DECODE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_en) begin
            mem[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        rd_data_b = mem[rd_addr_b];
        if (wb_en && (wb_addr == rd_addr_a)) rd_data_a = wb_data;
        if (wb_en && (wb_addr == rd_addr_b)) rd_data_b = wb_data;
    end

endmodule : regfile_bypass

// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage
//   Decode stage: reads operands from a bypassed register file, selects
//   operand B (immediate or register) and registers the result into the
//   ID/EX pipeline register.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     in_valid                  decode-slot instruction valid
//     stall, flush              hold / kill the ID/EX register (flush wins)
//     src_addr, dst_addr        read port A / read port B (also destination)
//     immediate, category       immediate operand; 1 selects it as operand B
//     wb_en, wb_addr, wb_data   register file write-back
//     out_valid, out_op_a, out_op_b, out_store_data, out_dst_addr
//                               ID/EX register contents
module decode_pipe_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = DECODE_DATA_W,
    parameter int ADDR_W = DECODE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0] immediate,
    input  logic              category,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [DATA_W-1:0] out_store_data,
    output logic [ADDR_W-1:0] out_dst_addr
);

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] op_b_sel;

    // Source address and operand-B select of the instruction held in ID/EX,
    // needed to refresh stale operands while the stage is stalled.
    logic [ADDR_W-1:0] held_src_addr;
    logic              held_category;

    regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_a (src_addr),
        .rd_addr_b (dst_addr),
        .rd_data_a (rd_a),
        .rd_data_b (rd_b)
    );

    assign op_b_sel = category ? immediate : rd_b;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid      <= 1'b0;
            out_op_a       <= '0;
            out_op_b       <= '0;
            out_store_data <= '0;
            out_dst_addr   <= '0;
            held_src_addr  <= '0;
            held_category  <= 1'b0;
        end else if (stall) begin
            // A held instruction must not keep a value that is overwritten
            // underneath it; bubbles are left alone.
            if (out_valid && wb_en) begin
                if (wb_addr == held_src_addr) begin
                    out_op_a <= wb_data;
                end
                if (wb_addr == out_dst_addr) begin
                    out_store_data <= wb_data;
                    if (!held_category) begin
                        out_op_b <= wb_data;
                    end
                end
            end
        end else begin
            out_valid      <= in_valid;
            out_op_a       <= rd_a;
            out_op_b       <= op_b_sel;
            out_store_data <= rd_b;
            out_dst_addr   <= dst_addr;
            held_src_addr  <= src_addr;
            held_category  <= category;
        end
    end

endmodule : decode_pipe_stage

// File: tb/tb_decode_pipe_stage.sv
module tb_decode_pipe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        category = 1'b0;

    logic [2:0]  src_addr = '0;
    logic [2:0]  dst_addr = '0;
    logic [15:0] immediate = '0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid;
    logic [15:0] out_op_a;
    logic [15:0] out_op_b;
    logic [15:0] out_store_data;
    logic [2:0]  out_dst_addr;

    logic [3:0]  w_src_addr = '0;
    logic [3:0]  w_dst_addr = '0;
    logic [31:0] w_immediate = '0;
    logic        w_wb_en = 1'b0;
    logic [3:0]  w_wb_addr = '0;
    logic [31:0] w_wb_data = '0;
    logic        w_out_valid;
    logic [31:0] w_out_op_a;
    logic [31:0] w_out_op_b;
    logic [31:0] w_out_store_data;
    logic [3:0]  w_out_dst_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_pipe_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .immediate      (immediate),
        .category       (category),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_op_a       (out_op_a),
        .out_op_b       (out_op_b),
        .out_store_data (out_store_data),
        .out_dst_addr   (out_dst_addr)
    );

    decode_pipe_stage #(.DATA_W(32), .ADDR_W(4)) dut_wide (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .stall          (1'b0),
        .flush          (1'b0),
        .src_addr       (w_src_addr),
        .dst_addr       (w_dst_addr),
        .immediate      (w_immediate),
        .category       (1'b0),
        .wb_en          (w_wb_en),
        .wb_addr        (w_wb_addr),
        .wb_data        (w_wb_data),
        .out_valid      (w_out_valid),
        .out_op_a       (w_out_op_a),
        .out_op_b       (w_out_op_b),
        .out_store_data (w_out_store_data),
        .out_dst_addr   (w_out_dst_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] s, input logic [2:0] d);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".op_a"},  {16'd0, out_op_a}, {16'd0, a});
        check({tag, ".op_b"},  {16'd0, out_op_b}, {16'd0, b});
        check({tag, ".store"}, {16'd0, out_store_data}, {16'd0, s});
        check({tag, ".dst"},   {29'd0, out_dst_addr}, {29'd0, d});
    endtask

    initial begin
        // reset
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("reset", 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);

        // every register reads zero after reset
        in_valid = 1'b1;
        category = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src_addr = 3'(i);
            dst_addr = 3'(7 - i);
            tick();
            check("rd0.op_a", {16'd0, out_op_a}, 32'h0);
            check("rd0.op_b", {16'd0, out_op_b}, 32'h0);
        end
        check("rd0.valid", {31'd0, out_valid}, 32'h1);

        // write-through bypass on port A
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        src_addr = 3'd3; dst_addr = 3'd0;
        tick();
        check("bypass_a", {16'd0, out_op_a}, 32'h1234);

        // r5 = 0x00AA, then immediate operand B
        wb_addr = 3'd5; wb_data = 16'h00AA;
        tick();
        wb_en = 1'b0;
        dst_addr = 3'd5; category = 1'b1; immediate = 16'hBEEF;
        tick();
        check_all("imm", 1'b1, 16'h1234, 16'hBEEF, 16'h00AA, 3'd5);

        // register operand B
        category = 1'b0;
        tick();
        check_all("regb", 1'b1, 16'h1234, 16'h00AA, 16'h00AA, 3'd5);

        // r2 = 0x0001, load src=2
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001; in_valid = 1'b0;
        tick();
        wb_en = 1'b0; in_valid = 1'b1; src_addr = 3'd2; dst_addr = 3'd5;
        tick();
        check_all("ld2", 1'b1, 16'h0001, 16'h00AA, 16'h00AA, 3'd5);

        // stall refresh of operand A (live src input deliberately changed)
        stall = 1'b1; src_addr = 3'd7; dst_addr = 3'd1;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0FF0;
        tick();
        check_all("refresh_a", 1'b1, 16'h0FF0, 16'h00AA, 16'h00AA, 3'd5);

        // stall refresh of store data and register operand B
        wb_addr = 3'd5; wb_data = 16'h5555;
        tick();
        check_all("refresh_b", 1'b1, 16'h0FF0, 16'h5555, 16'h5555, 3'd5);

        // non-matching write during stall holds everything
        wb_addr = 3'd4; wb_data = 16'h9999;
        tick();
        check_all("stall_hold", 1'b1, 16'h0FF0, 16'h5555, 16'h5555, 3'd5);

        // src == dst: same value on both ports, both refreshed together
        stall = 1'b0; wb_en = 1'b0; src_addr = 3'd5; dst_addr = 3'd5;
        tick();
        check_all("same_addr", 1'b1, 16'h5555, 16'h5555, 16'h5555, 3'd5);
        stall = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hABCD;
        tick();
        check_all("refresh_both", 1'b1, 16'hABCD, 16'hABCD, 16'hABCD, 3'd5);

        // held immediate is not overwritten by refresh
        stall = 1'b0; wb_en = 1'b0; src_addr = 3'd2; category = 1'b1; immediate = 16'h1111;
        tick();
        check_all("ld_imm", 1'b1, 16'h0FF0, 16'h1111, 16'hABCD, 3'd5);
        stall = 1'b1; category = 1'b0; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h7777;
        tick();
        check_all("refresh_imm", 1'b1, 16'h0FF0, 16'h1111, 16'h7777, 3'd5);

        // stall + flush -> bubble
        flush = 1'b1; wb_en = 1'b0;
        tick();
        check_all("flush_stall", 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);

        // stalled bubble is not refreshed, but the write still lands (r0)
        flush = 1'b0; wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'h4242;
        tick();
        check_all("bubble_stall", 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);

        // in_valid=0 still loads the fields
        stall = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
        src_addr = 3'd3; dst_addr = 3'd0; category = 1'b0;
        tick();
        check_all("inv_load", 1'b0, 16'h1234, 16'h4242, 16'h4242, 3'd0);

        // write-through bypass on port B
        in_valid = 1'b1; wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h6666;
        src_addr = 3'd6; dst_addr = 3'd6;
        tick();
        check_all("bypass_b", 1'b1, 16'h6666, 16'h6666, 16'h6666, 3'd6);

        // reset during stall overrides write-back and stall
        stall = 1'b1; rst = 1'b1; wb_addr = 3'd1; wb_data = 16'h0101;
        tick();
        check_all("rst_stall", 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        rst = 1'b0; stall = 1'b0; wb_en = 1'b0; src_addr = 3'd1; dst_addr = 3'd3;
        tick();
        check_all("rst_clear", 1'b1, 16'h0, 16'h0, 16'h0, 3'd3);

        // wide instance
        w_wb_en = 1'b1; w_wb_addr = 4'd15; w_wb_data = 32'hDEADBEEF; w_src_addr = 4'd15;
        tick();
        check("wide_bypass", w_out_op_a, 32'hDEADBEEF);
        w_wb_en = 1'b0; w_dst_addr = 4'd15;
        tick();
        check("wide_op_a", w_out_op_a, 32'hDEADBEEF);
        check("wide_op_b", w_out_op_b, 32'hDEADBEEF);
        check("wide_dst", {28'd0, w_out_dst_addr}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_decode_pipe_stage

// File: doc/decode_pipe_stage.md
DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  decode-slot instruction valid.
REQ-006 SHALL have port stall  input  1  hold ID/EX register contents.
REQ-007 SHALL have port flush  input  1  kill ID/EX contents (bubble).
REQ-008 SHALL have port src_addr  input  ADDR_W  read port A address.
REQ-009 SHALL have port dst_addr  input  ADDR_W  read port B address / destination.
REQ-010 SHALL have port immediate  input  DATA_W  immediate operand.
REQ-011 SHALL have port category  input  1  1 = operand B from immediate, 0 = from port B.
REQ-012 SHALL have port wb_en  input  1  write-back enable.
REQ-013 SHALL have port wb_addr  input  ADDR_W  write-back address.
REQ-014 SHALL have port wb_data  input  DATA_W  write-back data.
REQ-015 SHALL have port out_valid  output  1  ID/EX valid.
REQ-016 SHALL have port out_op_a  output  DATA_W  ALU operand A.
REQ-017 SHALL have port out_op_b  output  DATA_W  ALU operand B (immediate or register).
REQ-018 SHALL have port out_store_data  output  DATA_W  port B register value, always.
REQ-019 SHALL have port out_dst_addr  output  ADDR_W  registered dst_addr.

Function
REQ-020 Register file SHALL hold NREGS x DATA_W; write on rising clk when wb_en=1, including while stall=1.
REQ-021 Reads SHALL be combinational with write-through bypass: if wb_en=1 and wb_addr equals a read address, that port returns wb_data in the same cycle.
REQ-022 Decode values SHALL be: a = portA(src_addr); b_reg = portB(dst_addr); b = category ? immediate : b_reg.
REQ-023 ID/EX register update priority SHALL be rst > flush > stall > load.
REQ-024 Load (no rst/flush/stall): out_valid<=in_valid, out_op_a<=a, out_op_b<=b, out_store_data<=b_reg, out_dst_addr<=dst_addr; latency exactly one cycle; fields loaded even when in_valid=0.
REQ-025 Flush SHALL set out_valid and all data outputs to 0 next cycle, regardless of stall.
REQ-026 Stall SHALL hold all outputs, except stall-refresh per REQ-027.
REQ-027 Stall-refresh: while stall=1, out_valid=1 and wb_en=1: if wb_addr == held src_addr then out_op_a<=wb_data; if wb_addr == out_dst_addr then out_store_data<=wb_data and, when held category=0, out_op_b<=wb_data; both may occur in the same cycle.
REQ-028 Held src_addr and category SHALL be stored internally alongside the ID/EX register.
REQ-029 src_addr == dst_addr SHALL return the same value on both ports.

Reset
REQ-030 rst SHALL clear every register file entry and all outputs, including held src_addr/category, to 0 on the next rising clk.
REQ-031 rst SHALL override wb_en, flush and stall in the same cycle; a mid-stall reset leaves out_valid=0.

Structure
REQ-032 Default DATA_W/ADDR_W constants SHALL live in shared package decode_pkg.
REQ-033 Register file with bypass SHALL be one sub-module, regfile_bypass, parametrised by DATA_W/ADDR_W; ID/EX register and refresh logic stay in decode_pipe_stage.

Verification
REQ-034 Reset then read r0..r7, category=0 -> out_op_a=out_op_b=0x0000, out_valid=0 after rst.
REQ-035 Write r3=0x1234 with src_addr=3 same cycle, in_valid=1 -> next cycle out_op_a=0x1234 (bypass).
REQ-036 r5=0x00AA, dst_addr=5, category=1, immediate=0xBEEF -> out_op_b=0xBEEF, out_store_data=0x00AA, out_dst_addr=5.
REQ-037 Load src=2 (r2=0x0001), then stall=1 and write r2=0x0FF0 -> out_op_a becomes 0x0FF0 while out_valid stays 1.
REQ-038 stall=1 and flush=1 together -> out_valid=0, all data outputs 0 next cycle.
REQ-039 ADDR_W=4, DATA_W=32: write r15=0xDEADBEEF, read src=15 -> out_op_a=0xDEADBEEF.
